// File: rtl/minesweeper_pkg.sv
// Shared minesweeper types and helpers: FSM states, board coordinates and the
// flat bitmap index used by the placer and the neighbour counter.
package minesweeper_pkg;

   // Largest board edge the coordinate width can address.
   localparam int unsigned MAX_DIM = 16;
   // Bitmap width; cells outside the configured board stay zero.
   localparam int unsigned CELLS   = MAX_DIM * MAX_DIM;

   typedef logic [3:0] coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DRAW  = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Flat bitmap index with a fixed MAX_DIM stride, independent of ROWS/COLS.
   function automatic logic [7:0] cell_index(input coord_t row, input coord_t col);
      return {row, col};
   endfunction

endpackage

// File: rtl/mine_neighbour_count.sv
// Counts mines among the eight neighbours of a cell. Neighbours that fall
// outside the ROWS x COLS board contribute nothing; the centre is excluded.
module mine_neighbour_count
   import minesweeper_pkg::*;
#(
   parameter int unsigned ROWS = 8,
   parameter int unsigned COLS = 8
)
(
   input  logic [CELLS-1:0] i_bitmap,
   input  coord_t           i_row,
   input  coord_t           i_col,
   output logic [3:0]       o_adj
);

   logic [3:0] w_sum;
   int         w_nr;
   int         w_nc;

   // Walk the 3x3 window and add every in-board neighbour bit.
   always_comb begin
      w_sum = '0;
      w_nr  = 0;
      w_nc  = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            w_nr = int'(i_row) + dr;
            w_nc = int'(i_col) + dc;
            if ((dr != 0 || dc != 0) &&
                w_nr >= 0 && w_nr < int'(ROWS) &&
                w_nc >= 0 && w_nc < int'(COLS)) begin
               w_sum = w_sum + 4'(i_bitmap[cell_index(coord_t'(w_nr), coord_t'(w_nc))]);
            end
         end
      end
   end

   assign o_adj = w_sum;

endmodule

// File: rtl/mine_placer.sv
// Mine placer: draws candidate cells from the LFSR byte stream and sets MINES
// bits in the board bitmap, skipping the first-click cell. A combinational read
// port returns the mine flag and neighbour count of any cell.
//
// Optional build macro MINE_PLACER_SAFE_ZONE_EN: when defined the whole 3x3
// neighbourhood of the first click is kept mine-free instead of the single cell.
//
// state | meaning
// IDLE  | waiting for start; done/err hold the last result
// CLEAR | one cycle wiping bitmap and counters
// DRAW  | one candidate per cycle until MINES placed or draw budget spent
// FIN   | one cycle publishing done/err, then back to IDLE
module mine_placer
   import minesweeper_pkg::*;
#(
   parameter int unsigned ROWS      = 8,
   parameter int unsigned COLS      = 8,
   parameter int unsigned MINES     = 10,
   parameter int unsigned MAX_DRAWS = 1024
)
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [3:0] i_safe_row,
   input  logic [3:0] i_safe_col,
   input  logic [7:0] i_rand_byte,
   input  logic [3:0] i_rd_row,
   input  logic [3:0] i_rd_col,
   output logic       o_rd_mine,
   output logic [3:0] o_rd_adj,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam int unsigned MINE_W = $clog2(MINES + 1);
   localparam int unsigned DRAW_W = $clog2(MAX_DRAWS + 1);

   localparam logic [MINE_W-1:0] MINES_C = MINE_W'(MINES);
   localparam logic [DRAW_W-1:0] DRAWS_C = DRAW_W'(MAX_DRAWS);
   // Five bits so a 16-wide board compares cleanly against 4-bit coordinates.
   localparam logic [4:0]        ROWS_C  = 5'(ROWS);
   localparam logic [4:0]        COLS_C  = 5'(COLS);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CELLS-1:0]    r_bitmap;
   logic [MINE_W-1:0]   r_mine_cnt;
   logic [DRAW_W-1:0]   r_draw_cnt;
   coord_t              r_safe_row;
   coord_t              r_safe_col;
   logic                r_done;
   logic                r_err;

   logic [7:0]          w_idx;
   coord_t              w_cand_row;
   coord_t              w_cand_col;
   logic [7:0]          w_cand_cell;
   logic                w_in_board;
   logic                w_safe_valid;
   logic                w_excluded;
   logic                w_accept;
   logic                w_last_mine;
   logic                w_last_draw;
   logic                w_start_acc;
   logic                w_finish;
   logic                w_rd_in_board;

   // The LFSR never emits zero, so idx spans 0..254 and cell (15,15) is never drawn.
   assign w_idx       = i_rand_byte - 8'd1;
   assign w_cand_row  = w_idx[3:0];
   assign w_cand_col  = w_idx[7:4];
   assign w_cand_cell = cell_index(w_cand_row, w_cand_col);

   assign w_in_board   = ({1'b0, w_cand_row} < ROWS_C) && ({1'b0, w_cand_col} < COLS_C);
   // An off-board first click excludes nothing, even with the zone enabled.
   assign w_safe_valid = ({1'b0, r_safe_row} < ROWS_C) && ({1'b0, r_safe_col} < COLS_C);

`ifdef MINE_PLACER_SAFE_ZONE_EN
   coord_t w_drow;
   coord_t w_dcol;

   assign w_drow = (w_cand_row >= r_safe_row) ? (w_cand_row - r_safe_row)
                                              : (r_safe_row - w_cand_row);
   assign w_dcol = (w_cand_col >= r_safe_col) ? (w_cand_col - r_safe_col)
                                              : (r_safe_col - w_cand_col);
   assign w_excluded = w_safe_valid && (w_drow <= 4'd1) && (w_dcol <= 4'd1);
`else
   assign w_excluded = w_safe_valid && (w_cand_row == r_safe_row) &&
                       (w_cand_col == r_safe_col);
`endif

   assign w_accept    = (r_state == DRAW) && w_in_board && !w_excluded &&
                        !r_bitmap[w_cand_cell];
   assign w_last_mine = w_accept && ((r_mine_cnt + MINE_W'(1)) == MINES_C);
   assign w_last_draw = (r_draw_cnt + DRAW_W'(1)) == DRAWS_C;
   assign w_start_acc = (r_state == IDLE) && i_start;
   assign w_finish    = (r_state == DRAW) && (w_state_nxt == FIN);

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; start is only honoured in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = CLEAR;
         CLEAR:   w_state_nxt = DRAW;
         DRAW:    if (w_last_mine || w_last_draw) w_state_nxt = FIN;
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bitmap, counters and latched first-click cell.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bitmap   <= '0;
         r_mine_cnt <= '0;
         r_draw_cnt <= '0;
         r_safe_row <= '0;
         r_safe_col <= '0;
      end else begin
         if (w_start_acc) begin
            r_safe_row <= i_safe_row;
            r_safe_col <= i_safe_col;
         end
         if (r_state == CLEAR) begin
            r_bitmap   <= '0;
            r_mine_cnt <= '0;
            r_draw_cnt <= '0;
         end else if (r_state == DRAW) begin
            r_draw_cnt <= r_draw_cnt + DRAW_W'(1);
            if (w_accept) begin
               r_bitmap[w_cand_cell] <= 1'b1;
               r_mine_cnt            <= r_mine_cnt + MINE_W'(1);
            end
         end
      end
   end

   // Result flags: cleared by an accepted start, set on the last DRAW cycle.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_start_acc) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_finish) begin
         r_done <= 1'b1;
         r_err  <= !w_last_mine;
      end
   end

   assign o_busy = (r_state == CLEAR) || (r_state == DRAW);
   assign o_done = r_done;
   assign o_err  = r_err;

   assign w_rd_in_board = ({1'b0, i_rd_row} < ROWS_C) && ({1'b0, i_rd_col} < COLS_C);
   assign o_rd_mine     = w_rd_in_board && r_bitmap[cell_index(i_rd_row, i_rd_col)];

   mine_neighbour_count #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_adj (
      .i_bitmap (r_bitmap),
      .i_row    (i_rd_row),
      .i_col    (i_rd_col),
      .o_adj    (o_rd_adj)
   );

endmodule
